// File: rtl/key_loader_pkg.sv
// key_loader_pkg: shared state encoding, default sizes and parity helper for the key loader
package key_loader_pkg;
    localparam int KEY_WIDTH_DEF = 16;
    localparam int MAX_FAIL_DEF  = 3;
    typedef enum logic [1:0] {IDLE, LOAD, ARMED, LOCKED} state_t;
    // Odd-parity indicator; zero-extension keeps it neutral for narrower vectors
    function automatic logic odd_parity(input logic [63:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/key_loader.sv
// key_loader: serially receives a key plus even-parity bit and presents only verified keys to a locked core
module key_loader
    import key_loader_pkg::*;
#(
    parameter int KEY_WIDTH = KEY_WIDTH_DEF,
    parameter int MAX_FAIL  = MAX_FAIL_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ser_valid,
    input  logic                 ser_data,
    output logic                 ser_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 locked
);
    localparam int CW = $clog2(KEY_WIDTH + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    state_t               state_q, state_d;
    logic [KEY_WIDTH-1:0] shadow_q, shadow_d, key_q, key_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]        fail_cnt_q, fail_cnt_d;
    logic                 valid_q, valid_d, perr_q, perr_d;
    logic                 hs;
    assign hs         = ser_valid && state_q == LOAD;
    assign ser_ready  = state_q == LOAD;
    assign busy       = state_q == LOAD;
    assign locked     = state_q == LOCKED;
    assign key_out    = key_q;
    assign key_valid  = valid_q;
    assign parity_err = perr_q;
    // Next-state: the shadow register collects bits and is copied to key_out only after parity passes
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        key_d      = key_q;
        bit_cnt_d  = bit_cnt_q;
        fail_cnt_d = fail_cnt_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = LOAD;
                shadow_d  = '0;
                bit_cnt_d = '0;
                perr_d    = 1'b0;
            end
            LOAD: if (start) begin
                shadow_d  = '0;
                bit_cnt_d = '0;
            end else if (hs && bit_cnt_q < CW'(KEY_WIDTH)) begin
                shadow_d  = shadow_q | (KEY_WIDTH'(ser_data) << bit_cnt_q);
                bit_cnt_d = bit_cnt_q + CW'(1);
            end else if (hs && (odd_parity(64'(shadow_q)) ^ ser_data) == 1'b0) begin
                state_d    = ARMED;
                key_d      = shadow_q;
                valid_d    = 1'b1;
                fail_cnt_d = '0;
            end else if (hs) begin
                perr_d     = 1'b1;
                fail_cnt_d = (fail_cnt_q == FW'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + FW'(1);
                state_d    = (fail_cnt_d == FW'(MAX_FAIL)) ? LOCKED : IDLE;
            end
            ARMED: if (start) begin
                state_d   = LOAD;
                key_d     = '0;
                valid_d   = 1'b0;
                shadow_d  = '0;
                bit_cnt_d = '0;
                perr_d    = 1'b0;
            end
            default: ;
        endcase
    end
    // State registers with asynchronous reset to the all-clear, key-withdrawn condition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            key_q      <= '0;
            bit_cnt_q  <= '0;
            fail_cnt_q <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            key_q      <= key_d;
            bit_cnt_q  <= bit_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
        end
    end
endmodule
